// File: rtl/ad7988_sample_framer.sv
// ad7988_sample_framer: buffers 16-bit ADC samples in a small FIFO and emits
// each as a SYNC/SEQ/MSB/LSB/CHK byte frame on a valid/ready stream.
module ad7988_sample_framer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   iData,
  input  logic                          iDataValid,
  output logic [7:0]                    oByte,
  output logic                          oByteValid,
  input  logic                          iByteReady,
  output logic                          oOverflow,
  input  logic                          iClrOvf,
  output logic [$clog2(FIFO_DEPTH):0]   oFifoLevel,
  output logic                          oBusy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, B_SYNC, B_SEQ, B_MSB, B_LSB, B_CHK} state_t;
  state_t        state_q, state_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [15:0]   hold_q, hold_d;
  logic [7:0]    seq_q, seq_d, byte_q, byte_d;
  logic          vld_q, vld_d, ovf_q, ovf_d;
  logic          xfer, empty, full, pop, push, drop;
  assign xfer  = vld_q & iByteReady;
  assign empty = lvl_q == '0;
  assign full  = lvl_q == LW'(FIFO_DEPTH);
  // a sample leaves the FIFO when idle or when the checksum byte is accepted
  assign pop   = !empty && (state_q == IDLE || (state_q == B_CHK && xfer));
  assign push  = iDataValid && (!full || pop);
  assign drop  = iDataValid && full && !pop;
  assign lvl_d = lvl_q + LW'(push) - LW'(pop);
  assign ovf_d = drop | (ovf_q & ~iClrOvf);
  assign oByte      = byte_q;
  assign oByteValid = vld_q;
  assign oOverflow  = ovf_q;
  assign oFifoLevel = lvl_q;
  assign oBusy      = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
      vld_q   <= 1'b0;
      seq_q   <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      lvl_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      seq_q   <= seq_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      lvl_q   <= lvl_d;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= iData;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = B_SYNC;
      B_SYNC:  if (xfer) state_d = B_SEQ;
      B_SEQ:   if (xfer) state_d = B_MSB;
      B_MSB:   if (xfer) state_d = B_LSB;
      B_LSB:   if (xfer) state_d = B_CHK;
      B_CHK:   if (xfer) state_d = pop ? B_SYNC : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    byte_d = byte_q;
    vld_d  = vld_q;
    seq_d  = seq_q;
    hold_d = pop ? mem_q[rp_q] : hold_q;
    case (state_q)
      IDLE: begin
        vld_d = pop;
        if (pop) byte_d = SYNC_BYTE;
      end
      B_SYNC: if (xfer) byte_d = seq_q;
      B_SEQ:  if (xfer) byte_d = hold_q[15:8];
      B_MSB:  if (xfer) byte_d = hold_q[7:0];
      B_LSB:  if (xfer) byte_d = seq_q ^ hold_q[15:8] ^ hold_q[7:0];
      B_CHK: if (xfer) begin
        seq_d = seq_q + 8'd1;
        vld_d = pop;
        if (pop) byte_d = SYNC_BYTE;
      end
      default: vld_d = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_ad7988_sample_framer.sv
// tb_ad7988_sample_framer: directed checks of framing, backpressure, FIFO
// overflow, sequence wrap and mid-frame reset against a byte-level model.
module tb_ad7988_sample_framer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] iData = '0;
  logic        iDataValid = 1'b0, iByteReady = 1'b0, iClrOvf = 1'b0;
  logic [7:0]  oByte;
  logic        oByteValid, oOverflow, oBusy;
  logic [2:0]  oFifoLevel;
  int          total = 0, bad = 0, cyc;
  logic [7:0]  rx[$], ex[$];
  logic [7:0]  sq = '0, held_q = '0;
  logic        stall_q = 1'b0;
  logic [15:0] d;

  always #5 clk = ~clk;

  ad7988_sample_framer dut (
    .clk(clk), .rst_n(rst_n), .iData(iData), .iDataValid(iDataValid),
    .oByte(oByte), .oByteValid(oByteValid), .iByteReady(iByteReady),
    .oOverflow(oOverflow), .iClrOvf(iClrOvf), .oFifoLevel(oFifoLevel), .oBusy(oBusy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    iData = v;
    iDataValid = 1'b1;
    step();
    iDataValid = 1'b0;
  endtask

  function automatic void frame(input logic [15:0] v);
    ex.push_back(8'hA5);
    ex.push_back(sq);
    ex.push_back(v[15:8]);
    ex.push_back(v[7:0]);
    ex.push_back(sq ^ v[15:8] ^ v[7:0]);
    sq = sq + 8'd1;
  endfunction

  task automatic drain(input int lim, input bit rnd, output int n);
    n = 0;
    while (rx.size() < ex.size() && n < lim) begin
      if (rnd) iByteReady = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("rx_count", rx.size(), ex.size());
    for (int i = 0; i < ex.size() && i < rx.size(); i++) chk("rx_byte", rx[i], ex[i]);
    rx.delete();
    ex.delete();
  endtask

  // byte collector plus hold-stable check while stalled
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) chk("hold_stable", {oByteValid, oByte}, {1'b1, held_q});
      if (oByteValid && iByteReady) rx.push_back(oByte);
      stall_q <= oByteValid && !iByteReady;
      held_q  <= oByte;
    end else stall_q <= 1'b0;
  end

  initial begin
    step();
    step();
    chk("rst_byte", oByte, 0);
    chk("rst_valid", oByteValid, 0);
    chk("rst_ovf", oOverflow, 0);
    chk("rst_lvl", oFifoLevel, 0);
    chk("rst_busy", oBusy, 0);
    rst_n = 1'b1;
    step();
    // basic frame and latency
    iByteReady = 1'b1;
    push(16'h1234);
    chk("t1_lat_valid", oByteValid, 0);
    chk("t1_lvl", oFifoLevel, 1);
    frame(16'h1234);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_byte", {oByteValid, oByte}, {1'b1, ex[k]});
      chk("t1_busy", oBusy, 1);
    end
    step();
    chk("t1_idle_valid", oByteValid, 0);
    chk("t1_idle_busy", oBusy, 0);
    drain(20, 1'b0, cyc);
    // random backpressure
    push(16'hBEEF);
    frame(16'hBEEF);
    drain(400, 1'b1, cyc);
    iByteReady = 1'b1;
    step();
    step();
    chk("t2_idle", oBusy, 0);
    // overflow while stalled
    iByteReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 16'(16'h1111 * (i + 1));
      push(d);
      if (i < 5) frame(d);
    end
    chk("t3_lvl", oFifoLevel, 4);
    chk("t3_ovf", oOverflow, 1);
    iByteReady = 1'b1;
    drain(100, 1'b0, cyc);
    chk("t3_gapless", cyc, 25);
    step();
    chk("t3_idle", oBusy, 0);
    chk("t3_ovf_sticky", oOverflow, 1);
    iClrOvf = 1'b1;
    step();
    iClrOvf = 1'b0;
    chk("t3_ovf_clr", oOverflow, 0);
    // push+pop at full, then clear vs overflow collision
    iByteReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 16'(16'hA001 + i);
      push(d);
      frame(d);
    end
    chk("t4_lvl_full", oFifoLevel, 4);
    chk("t4_ovf0", oOverflow, 0);
    iByteReady = 1'b1;
    repeat (4) step();
    iData = 16'h7777;
    iDataValid = 1'b1;
    step();
    iDataValid = 1'b0;
    iByteReady = 1'b0;
    frame(16'h7777);
    chk("t4_pushpop_lvl", oFifoLevel, 4);
    chk("t4_pushpop_ovf", oOverflow, 0);
    chk("t4_next_sync", {oByteValid, oByte}, {1'b1, 8'hA5});
    iData = 16'h8888;
    iDataValid = 1'b1;
    iClrOvf = 1'b1;
    step();
    iDataValid = 1'b0;
    chk("t4_set_wins", oOverflow, 1);
    chk("t4_drop_lvl", oFifoLevel, 4);
    step();
    iClrOvf = 1'b0;
    chk("t4_clr", oOverflow, 0);
    iByteReady = 1'b1;
    drain(200, 1'b0, cyc);
    // sustained stream with sequence wrap
    for (int i = 0; i < 260; i++) begin
      d = 16'(i * 40503 + 7);
      frame(d);
      push(d);
      repeat (5) step();
    end
    drain(100, 1'b0, cyc);
    chk("t5_ovf", oOverflow, 0);
    step();
    // reset in the middle of a frame
    push(16'hC3C3);
    repeat (3) step();
    chk("t6_in_msb", {oByteValid, oByte}, {1'b1, 8'hC3});
    ex.push_back(8'hA5);
    ex.push_back(sq);
    rst_n = 1'b0;
    #1;
    chk("t6_byte", oByte, 0);
    chk("t6_valid", oByteValid, 0);
    chk("t6_busy", oBusy, 0);
    chk("t6_lvl", oFifoLevel, 0);
    chk("t6_ovf", oOverflow, 0);
    sq = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    push(16'h0102);
    frame(16'h0102);
    drain(50, 1'b0, cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
